// File: rtl/inst_loader.sv
// Boot-time program loader: turns a UART byte stream (big-endian word-count header
// followed by big-endian instruction words) into instruction-memory writes from address 0.
module inst_loader #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [1:0] {HDR, BODY, DONE, ERR} state_t;

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    state_t              state_q, state_d;
    logic [1:0]          byteIdx_q, byteIdx_d;
    logic [23:0]         shift_q, shift_d;
    logic [31:0]         n_q, n_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         word;

    // Only the first three bytes of a group are kept; the fourth completes the word on the fly.
    assign word = {shift_q, in_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HDR;
            byteIdx_q <= '0;
            shift_q   <= '0;
            n_q       <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            byteIdx_q <= byteIdx_d;
            shift_q   <= shift_d;
            n_q       <= n_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        byteIdx_d = byteIdx_q;
        shift_d   = shift_q;
        n_d       = n_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;

        unique case (state_q)
            HDR: begin
                if (in_valid) begin
                    byteIdx_d = byteIdx_q + 2'd1;
                    shift_d   = {shift_q[15:0], in_data};
                    if (byteIdx_q == 2'd3) begin
                        n_d    = word;
                        wptr_d = '0;
                        if (word == 32'd0) begin
                            state_d = DONE;
                        end else if ({1'b0, word} > DEPTH) begin
                            state_d = ERR;
                        end else begin
                            state_d = BODY;
                        end
                    end
                end
            end
            BODY: begin
                if (in_valid) begin
                    byteIdx_d = byteIdx_q + 2'd1;
                    shift_d   = {shift_q[15:0], in_data};
                    if (byteIdx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wptr_q;
                        data_d  = word;
                        wptr_d  = wptr_q + 1'b1;
                        count_d = count_q + 1'b1;
                    end
                end
                // count_q already includes the write being presented this cycle.
                if (we_q && (32'(count_q) == n_q)) begin
                    state_d = DONE;
                end
            end
            DONE, ERR: begin
                if (start) begin
                    state_d   = HDR;
                    byteIdx_d = '0;
                    shift_d   = '0;
                    n_d       = '0;
                    wptr_d    = '0;
                    count_d   = '0;
                end
            end
            default: state_d = HDR;
        endcase
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_data    = data_q;
    assign done         = (state_q == DONE);
    assign err          = (state_q == ERR);
    assign words_loaded = count_q;

endmodule
